// File: rtl/nms_frame_ctrl.sv
// Frame sequencer for the FAST/NMS corner pipeline: pixel handshake, global
// clock enable, beat coordinates and end-of-frame flush of the delay lines.
module nms_frame_ctrl #(
  parameter int unsigned COL_NUM    = 640,
  parameter int unsigned ROW_NUM    = 480,
  parameter int unsigned FAST_DELAY = 12,
  parameter int unsigned NMS_SIZE   = 3,
  parameter int unsigned FLUSH_LEN  = COL_NUM + FAST_DELAY + NMS_SIZE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic        out_ready,
  output logic        ce,
  output logic [9:0]  x_coord,
  output logic [9:0]  y_coord,
  output logic        xy_coord_vld,
  output logic        score_eol,
  output logic        busy,
  output logic        frame_done,
  output logic        start_err,
  output logic [15:0] frame_cnt
);

  localparam int unsigned CW   = 10;
  localparam int unsigned FW   = 11;
  localparam int unsigned CNTW = 16;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   x_q, x_d;
  logic [CW-1:0]   y_q, y_d;
  logic [FW-1:0]   fl_q, fl_d;
  logic [CNTW-1:0] frame_cnt_q, frame_cnt_d;
  logic            start_err_q, start_err_d;

  logic x_last_c, y_last_c, fl_last_c;

  // Same-cycle handshake and enables: no registered bubble on stalls.
  always_comb begin
    x_last_c     = (x_q == CW'(COL_NUM - 1));
    y_last_c     = (y_q == CW'(ROW_NUM - 1));
    fl_last_c    = (fl_q == FW'(FLUSH_LEN - 1));
    pix_ready    = (state_q == S_ACTIVE) & out_ready & ~abort;
    ce           = (pix_ready & pix_valid) | ((state_q == S_FLUSH) & out_ready & ~abort);
    xy_coord_vld = ce & (state_q == S_ACTIVE);
    score_eol    = ce & x_last_c;
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    fl_d        = fl_q;
    frame_cnt_d = frame_cnt_q;
    start_err_d = start_err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_ACTIVE;
          start_err_d = 1'b0;
        end
      end
      S_ACTIVE: begin
        if (ce) begin
          if (x_last_c) begin
            x_d = '0;
            if (y_last_c) begin
              y_d     = '0;
              fl_d    = '0;
              state_d = S_FLUSH;
            end else begin
              y_d = y_q + CW'(1);
            end
          end else begin
            x_d = x_q + CW'(1);
          end
        end
      end
      S_FLUSH: begin
        // y holds 0 here; x keeps wrapping so line ends still get marked
        if (ce) begin
          x_d  = x_last_c ? '0 : x_q + CW'(1);
          fl_d = fl_q + FW'(1);
          if (fl_last_c) begin
            state_d     = S_DONE;
            x_d         = '0;
            fl_d        = '0;
            frame_cnt_d = frame_cnt_q + CNTW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (start && (state_q != S_IDLE)) begin
      start_err_d = 1'b1;
    end

    // Abort wins over everything, including a start in IDLE
    if (abort) begin
      state_d     = S_IDLE;
      x_d         = '0;
      y_d         = '0;
      fl_d        = '0;
      frame_cnt_d = frame_cnt_q;
      if (state_q == S_IDLE) begin
        start_err_d = start_err_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      fl_q        <= '0;
      frame_cnt_q <= '0;
      start_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      fl_q        <= fl_d;
      frame_cnt_q <= frame_cnt_d;
      start_err_q <= start_err_d;
    end
  end

  always_comb begin
    x_coord    = x_q;
    y_coord    = y_q;
    busy       = (state_q != S_IDLE);
    frame_done = (state_q == S_DONE);
    start_err  = start_err_q;
    frame_cnt  = frame_cnt_q;
  end

endmodule

// File: tb/tb_nms_frame_ctrl.sv
// Self-checking bench for nms_frame_ctrl: directed scenarios plus random
// handshake traffic against a pixel-index based frame model.
module tb_nms_frame_ctrl;

  localparam int unsigned COL    = 4;
  localparam int unsigned ROW    = 3;
  localparam int unsigned FD     = 2;
  localparam int unsigned NMS    = 3;
  localparam int unsigned FL_LEN = COL + FD + NMS;
  localparam int unsigned NPIX   = COL * ROW;

  logic        clk, rst_n, start, abort, pix_valid, out_ready;
  logic        pix_ready, ce, xy_coord_vld, score_eol, busy, frame_done, start_err;
  logic [9:0]  x_coord, y_coord;
  logic [15:0] frame_cnt;

  nms_frame_ctrl #(
    .COL_NUM(COL), .ROW_NUM(ROW), .FAST_DELAY(FD), .NMS_SIZE(NMS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .out_ready(out_ready),
    .ce(ce), .x_coord(x_coord), .y_coord(y_coord), .xy_coord_vld(xy_coord_vld),
    .score_eol(score_eol), .busy(busy), .frame_done(frame_done),
    .start_err(start_err), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: phase 0 idle, 1 pixels, 2 flush, 3 done; progress as beat indices
  int ph = 0, pix = 0, fl = 0, frames = 0;
  bit err = 0;

  int cyc, done_cyc, n_done, n_pix, n_fl, n_eol_a, n_eol_f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_ce();
    return ((ph == 1) && out_ready && pix_valid && !abort) ||
           ((ph == 2) && out_ready && !abort);
  endfunction

  task automatic check_cycle();
    logic ece;
    int ex, ey;
    ece = exp_ce();
    ex = 0;
    ey = 0;
    if (ph == 1) begin
      ex = pix % COL;
      ey = pix / COL;
    end else if (ph == 2) begin
      ex = fl % COL;
    end
    chk("pix_ready", 32'(pix_ready), 32'((ph == 1) && out_ready && !abort));
    chk("ce", 32'(ce), 32'(ece));
    chk("xy_coord_vld", 32'(xy_coord_vld), 32'(ece && (ph == 1)));
    chk("score_eol", 32'(score_eol), 32'(ece && (ex == COL - 1)));
    chk("x_coord", 32'(x_coord), 32'(ex));
    chk("y_coord", 32'(y_coord), 32'(ey));
    chk("busy", 32'(busy), 32'(ph != 0));
    chk("frame_done", 32'(frame_done), 32'(ph == 3));
    chk("frame_cnt", 32'(frame_cnt), 32'(frames % 65536));
    chk("start_err", 32'(start_err), 32'(err));
    if (xy_coord_vld === 1'b1) n_pix++;
    if (ce === 1'b1 && xy_coord_vld === 1'b0) n_fl++;
    if (score_eol === 1'b1 && xy_coord_vld === 1'b1) n_eol_a++;
    if (score_eol === 1'b1 && xy_coord_vld === 1'b0) n_eol_f++;
    if (frame_done === 1'b1) begin
      n_done++;
      if (done_cyc == 0) done_cyc = cyc;
    end
  endtask

  task automatic advance();
    logic ece;
    ece = exp_ce();
    if (start && ph != 0) err = 1;
    if (abort) begin
      ph  = 0;
      pix = 0;
      fl  = 0;
    end else begin
      case (ph)
        0: if (start) begin ph = 1; pix = 0; err = 0; end
        1: if (ece) begin
             pix++;
             if (pix == NPIX) begin ph = 2; fl = 0; end
           end
        2: if (ece) begin
             fl++;
             if (fl == FL_LEN) begin ph = 3; frames++; end
           end
        default: ph = 0;
      endcase
    end
  endtask

  task automatic cycle(input logic st, input logic pv, input logic ov, input logic ab);
    start = st; pix_valid = pv; out_ready = ov; abort = ab;
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    advance();
    #1;
    cyc++;
  endtask

  task automatic clear_stats();
    cyc = 1; done_cyc = 0; n_done = 0;
    n_pix = 0; n_fl = 0; n_eol_a = 0; n_eol_f = 0;
  endtask

  // mode 0 full rate, 1 two stalls, 2 toggling valid, 3 stray start, 4 random
  task automatic run_frame(input int mode);
    int guard, stall;
    bit s1, s2;
    logic st, pv, ov;
    guard = 0; stall = 0; s1 = 0; s2 = 0;
    clear_stats();
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    while (ph != 0 && guard < 400) begin
      st = 1'b0; pv = 1'b1; ov = 1'b1;
      case (mode)
        1: begin
          if (stall == 0 && ph == 1 && pix == 6 && !s1) begin s1 = 1; stall = 5; end
          if (stall == 0 && ph == 2 && fl == 4 && !s2) begin s2 = 1; stall = 5; end
          ov = (stall == 0);
          if (stall > 0) stall--;
        end
        2: pv = (cyc % 2 == 0);
        3: if (ph == 1 && pix == 3 && !s1) begin s1 = 1; st = 1'b1; end
        4: begin
          pv = ($urandom_range(0, 3) != 0);
          ov = ($urandom_range(0, 3) != 0);
        end
        default: ;
      endcase
      cycle(st, pv, ov, 1'b0);
      guard++;
    end
    chk("frame_timeout", 32'(guard < 400), 32'd1);
    chk("pix_beats", 32'(n_pix), 32'(NPIX));
    chk("flush_beats", 32'(n_fl), 32'(FL_LEN));
    chk("eol_active", 32'(n_eol_a), 32'(ROW));
    chk("eol_flush", 32'(n_eol_f), 32'(FL_LEN / COL));
    chk("done_pulses", 32'(n_done), 32'd1);
  endtask

  initial begin
    int g;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; pix_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_x", 32'(x_coord), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk);
    check_cycle();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_frame(0);
    chk("done_cycle_nostall", 32'(done_cyc), 32'(1 + NPIX + FL_LEN + 1));

    run_frame(1);
    chk("done_cycle_stall", 32'(done_cyc), 32'(1 + NPIX + FL_LEN + 1 + 10));

    run_frame(2);

    // Abort at pixel (1,1) with a valid pixel presented
    clear_stats();
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    g = 0;
    while (!(ph == 1 && pix == 5) && g < 50) begin cycle(1'b0, 1'b1, 1'b1, 1'b0); g++; end
    chk("abort_at_x", 32'(x_coord), 32'd1);
    chk("abort_at_y", 32'(y_coord), 32'd1);
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (30) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    chk("abort_no_done", 32'(n_done), 32'd0);
    chk("abort_frame_cnt", 32'(frame_cnt), 32'd3);
    run_frame(0);

    run_frame(3);
    chk("start_err_sticky", 32'(start_err), 32'd1);
    run_frame(0);
    chk("start_err_cleared", 32'(start_err), 32'd0);

    repeat (3) run_frame(4);

    // Reset asserted mid-flush
    clear_stats();
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    g = 0;
    while (!(ph == 2 && fl == 5) && g < 50) begin cycle(1'b0, 1'b1, 1'b1, 1'b0); g++; end
    start = 1'b0; pix_valid = 1'b1; out_ready = 1'b1; abort = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    ph = 0; pix = 0; fl = 0; frames = 0; err = 0;
    chk("rstmid_ce", 32'(ce), 32'd0);
    chk("rstmid_pix_ready", 32'(pix_ready), 32'd0);
    chk("rstmid_x", 32'(x_coord), 32'd0);
    chk("rstmid_y", 32'(y_coord), 32'd0);
    chk("rstmid_eol", 32'(score_eol), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_done", 32'(frame_done), 32'd0);
    chk("rstmid_frame_cnt", 32'(frame_cnt), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    n_done = 0;
    repeat (20) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    chk("rstmid_no_done", 32'(n_done), 32'd0);
    run_frame(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
